// File: rtl/cam_cfg_pkg.sv
// -----------------------------------------------------------------------------
// cam_cfg_pkg
//   Shared definitions for the OV5640 configuration sequencer:
//   - sequencer state encoding
//   - LUT entry layout {dev_addr, reg_addr, reg_data}
//   - table terminator and sensor soft-reset register constants
//   - helper that recognises a soft-reset write
// -----------------------------------------------------------------------------
package cam_cfg_pkg;

    // Width of the shared delay counter; 2^20 covers the 20 ms power-up wait at 50 MHz.
    localparam int TIMER_W = 20;

    // Device address value that marks the end of the register table.
    localparam logic [7:0]  TERMINATOR_DEV_ADDR = 8'hFF;

    // System control register; setting bit 7 puts the sensor into software reset.
    localparam logic [15:0] SOFT_RESET_REG = 16'h3008;
    localparam int          SOFT_RESET_BIT = 7;

    typedef enum logic [2:0] {
        ST_WAIT_PWR  = 3'd0,
        ST_FETCH     = 3'd1,
        ST_CHECK     = 3'd2,
        ST_REQ       = 3'd3,
        ST_SETTLE    = 3'd4,
        ST_RETRY_GAP = 3'd5,
        ST_DONE      = 3'd6,
        ST_ERROR     = 3'd7
    } cfg_state_t;

    typedef struct packed {
        logic [7:0]  dev_addr;
        logic [15:0] reg_addr;
        logic [7:0]  reg_data;
    } lut_entry_t;

    // True when the write will put the sensor into soft reset and needs a settle wait.
    function automatic logic is_soft_reset(input logic [15:0] reg_addr,
                                           input logic [7:0]  reg_data);
        return (reg_addr == SOFT_RESET_REG) && reg_data[SOFT_RESET_BIT];
    endfunction

endpackage

// File: rtl/cfg_delay_timer.sv
// -----------------------------------------------------------------------------
// cfg_delay_timer
//   Single load/down-counter shared by the power-up wait and the soft-reset
//   settle wait. After reset it starts counting down from RESET_VALUE, so the
//   power-up wait needs no explicit load. 'expired' is registered and rises
//   exactly load_value clock edges after the load edge.
//
// Ports
//   clk         in   1        system clock
//   rst         in   1        asynchronous active-high reset
//   load        in   1        load load_value into the counter this edge
//   load_value  in   WIDTH    number of cycles to wait
//   expired     out  1        counter has reached zero (level until next load)
// -----------------------------------------------------------------------------
module cfg_delay_timer #(
    parameter int              WIDTH       = 20,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expired
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic             RESET_EXPIRED = (RESET_VALUE == ZERO);

    logic [WIDTH-1:0] count;

    // Down-counter with registered expiry flag; expiry is pre-computed from count<=1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= RESET_VALUE;
            expired <= RESET_EXPIRED;
        end else if (load) begin
            count   <= load_value;
            expired <= (load_value == ZERO);
        end else if (count != ZERO) begin
            count   <= count - ONE;
            expired <= (count <= ONE);
        end else begin
            count   <= ZERO;
            expired <= 1'b1;
        end
    end

endmodule

// File: rtl/ov5640_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// ov5640_cfg_sequencer
//   Walks the camera register look-up table from index 0, issuing each entry
//   {dev_addr[31:24], reg_addr[23:8], reg_data[7:0]} as one write request to the
//   I2C master. Waits POWERUP_CYCLES after reset before the first fetch, waits
//   RESET_WAIT_CYCLES after a soft-reset write (0x3008 with bit 7 set), stops on
//   the terminator (dev_addr 0xFF) and reports done/error as levels.
//
// Build option
//   CFG_RETRY_EN  when defined, an entry that ends in an I2C error is re-issued
//                 after a 1-cycle gap, up to MAX_RETRIES times; the next
//                 consecutive error aborts. Undefined: first error aborts and no
//                 retry counter exists.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   cfg_restart         1-cycle pulse, restart from index 0 when in DONE/ERROR
//   lut_index/lut_data  LUT address out, combinational LUT entry in
//   i2c_write_req       write request, held until i2c_write_req_ack
//   i2c_write_req_ack   1-cycle transfer-finished pulse, i2c_error valid with it
//   i2c_slave_dev_addr, i2c_write_addr, i2c_write_data   current entry fields
//   cfg_busy/cfg_done/cfg_error   sequence status
//   reg_count           writes acknowledged without error
// -----------------------------------------------------------------------------
module ov5640_cfg_sequencer
    import cam_cfg_pkg::*;
#(
    parameter int unsigned POWERUP_CYCLES    = 1_000_000,
    parameter int unsigned RESET_WAIT_CYCLES = 250_000,
    parameter int unsigned MAX_ENTRIES       = 1023,
    parameter int unsigned MAX_RETRIES       = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_restart,
    output logic [9:0]  lut_index,
    input  logic [31:0] lut_data,
    output logic        i2c_write_req,
    input  logic        i2c_write_req_ack,
    input  logic        i2c_error,
    output logic [7:0]  i2c_slave_dev_addr,
    output logic [15:0] i2c_write_addr,
    output logic [7:0]  i2c_write_data,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_error,
    output logic [9:0]  reg_count
);

    localparam logic [TIMER_W-1:0] POWERUP_LOAD = TIMER_W'(POWERUP_CYCLES);
    localparam logic [TIMER_W-1:0] SETTLE_LOAD  = TIMER_W'(RESET_WAIT_CYCLES);
    localparam logic [9:0]         LAST_INDEX   = 10'(MAX_ENTRIES);

`ifdef CFG_RETRY_EN
    localparam int             RETRY_W     = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);
    localparam logic [RETRY_W-1:0] RETRY_ONE   = {{(RETRY_W-1){1'b0}}, 1'b1};
    logic [RETRY_W-1:0] retry_cnt;
`endif

    cfg_state_t state;
    lut_entry_t entry;
    logic       timer_load;
    logic       timer_expired;

    assign entry = lut_entry_t'(lut_data);

    // The power-up wait runs from the timer's reset value; only the settle wait loads it.
    cfg_delay_timer #(
        .WIDTH       (TIMER_W),
        .RESET_VALUE (POWERUP_LOAD)
    ) u_delay_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (SETTLE_LOAD),
        .expired    (timer_expired)
    );

    // Arm the settle wait on the same edge that accepts a successful soft-reset write.
    always_comb begin
        timer_load = 1'b0;
        if ((state == ST_REQ) && i2c_write_req_ack && !i2c_error &&
            is_soft_reset(i2c_write_addr, i2c_write_data)) begin
            timer_load = 1'b1;
        end else begin
            timer_load = 1'b0;
        end
    end

    // Sequencer FSM; every output is a register updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= ST_WAIT_PWR;
            lut_index          <= 10'd0;
            i2c_write_req      <= 1'b0;
            i2c_slave_dev_addr <= 8'd0;
            i2c_write_addr     <= 16'd0;
            i2c_write_data     <= 8'd0;
            cfg_busy           <= 1'b1;
            cfg_done           <= 1'b0;
            cfg_error          <= 1'b0;
            reg_count          <= 10'd0;
`ifdef CFG_RETRY_EN
            retry_cnt          <= {RETRY_W{1'b0}};
`endif
        end else begin
            case (state)
                ST_WAIT_PWR: begin
                    if (timer_expired) begin
                        state <= ST_FETCH;
                    end else begin
                        state <= ST_WAIT_PWR;
                    end
                end

                ST_FETCH: begin
                    i2c_slave_dev_addr <= entry.dev_addr;
                    i2c_write_addr     <= entry.reg_addr;
                    i2c_write_data     <= entry.reg_data;
                    state              <= ST_CHECK;
                end

                // Terminator wins over the index limit so a table that ends exactly at
                // the limit still completes.
                ST_CHECK: begin
                    if (i2c_slave_dev_addr == TERMINATOR_DEV_ADDR) begin
                        state    <= ST_DONE;
                        cfg_busy <= 1'b0;
                        cfg_done <= 1'b1;
                    end else if (lut_index == LAST_INDEX) begin
                        state     <= ST_ERROR;
                        cfg_busy  <= 1'b0;
                        cfg_error <= 1'b1;
                    end else begin
                        state         <= ST_REQ;
                        i2c_write_req <= 1'b1;
                    end
                end

                ST_REQ: begin
                    if (i2c_write_req_ack) begin
                        i2c_write_req <= 1'b0;
                        if (!i2c_error) begin
                            reg_count <= reg_count + 10'd1;
                            lut_index <= lut_index + 10'd1;
`ifdef CFG_RETRY_EN
                            retry_cnt <= {RETRY_W{1'b0}};
`endif
                            if (is_soft_reset(i2c_write_addr, i2c_write_data)) begin
                                state <= ST_SETTLE;
                            end else begin
                                state <= ST_FETCH;
                            end
                        end else begin
`ifdef CFG_RETRY_EN
                            if (retry_cnt < RETRY_LIMIT) begin
                                retry_cnt <= retry_cnt + RETRY_ONE;
                                state     <= ST_RETRY_GAP;
                            end else begin
                                state     <= ST_ERROR;
                                cfg_busy  <= 1'b0;
                                cfg_error <= 1'b1;
                            end
`else
                            // lut_index and reg_count stay frozen on the failing entry.
                            state     <= ST_ERROR;
                            cfg_busy  <= 1'b0;
                            cfg_error <= 1'b1;
`endif
                        end
                    end else begin
                        state <= ST_REQ;
                    end
                end

                ST_SETTLE: begin
                    if (timer_expired) begin
                        state <= ST_FETCH;
                    end else begin
                        state <= ST_SETTLE;
                    end
                end

                // One idle cycle with req low, then the same (unchanged) fields are re-issued.
                ST_RETRY_GAP: begin
                    i2c_write_req <= 1'b1;
                    state         <= ST_REQ;
                end

                ST_DONE, ST_ERROR: begin
                    if (cfg_restart) begin
                        state     <= ST_FETCH;
                        cfg_busy  <= 1'b1;
                        cfg_done  <= 1'b0;
                        cfg_error <= 1'b0;
                        reg_count <= 10'd0;
                        lut_index <= 10'd0;
`ifdef CFG_RETRY_EN
                        retry_cnt <= {RETRY_W{1'b0}};
`endif
                    end else begin
                        state <= state;
                    end
                end

                // Unreachable encoding: fail safe with the request withdrawn.
                default: begin
                    state         <= ST_ERROR;
                    i2c_write_req <= 1'b0;
                    cfg_busy      <= 1'b0;
                    cfg_done      <= 1'b0;
                    cfg_error     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ov5640_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// tb_ov5640_cfg_sequencer
//   Directed bench: LUT model array, I2C master BFM with programmable ack delay
//   and error injection on one index, hand-computed expectations.
//   Short waits: POWERUP_CYCLES=100, RESET_WAIT_CYCLES=50, MAX_ENTRIES=8.
// -----------------------------------------------------------------------------
module tb_ov5640_cfg_sequencer;

    localparam int P_PWR    = 100;
    localparam int P_SETTLE = 50;
    localparam int P_MAXE   = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_restart = 1'b0;
    logic [9:0]  lut_index;
    logic [31:0] lut_data;
    logic        i2c_write_req;
    logic        i2c_write_req_ack;
    logic        i2c_error;
    logic [7:0]  i2c_slave_dev_addr;
    logic [15:0] i2c_write_addr;
    logic [7:0]  i2c_write_data;
    logic        cfg_busy;
    logic        cfg_done;
    logic        cfg_error;
    logic [9:0]  reg_count;

    logic [31:0] lut_mem [0:15];

    // BFM configuration (written by the stimulus only)
    int          ack_delay = 2;
    logic [9:0]  err_idx   = 10'd0;
    int          err_n     = 0;

    // BFM state and log (written by the BFM only)
    int          cyc = 0;
    int          bfm_cnt;
    int          err_seen;
    int          n_acks;
    int          n_reqs;
    logic        req_d;
    logic [31:0] log_entry [0:31];
    int          log_cyc   [0:31];
    int          start_cyc [0:31];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          rel_cyc;

    always #5 clk = ~clk;

    assign lut_data = lut_mem[lut_index[3:0]];

    ov5640_cfg_sequencer #(
        .POWERUP_CYCLES    (P_PWR),
        .RESET_WAIT_CYCLES (P_SETTLE),
        .MAX_ENTRIES       (P_MAXE),
        .MAX_RETRIES       (3)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .cfg_restart        (cfg_restart),
        .lut_index          (lut_index),
        .lut_data           (lut_data),
        .i2c_write_req      (i2c_write_req),
        .i2c_write_req_ack  (i2c_write_req_ack),
        .i2c_error          (i2c_error),
        .i2c_slave_dev_addr (i2c_slave_dev_addr),
        .i2c_write_addr     (i2c_write_addr),
        .i2c_write_data     (i2c_write_data),
        .cfg_busy           (cfg_busy),
        .cfg_done           (cfg_done),
        .cfg_error          (cfg_error),
        .reg_count          (reg_count)
    );

    // Free-running cycle counter for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    // I2C master BFM: acks after ack_delay+1 cycles of req, logs consumed acks.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            i2c_write_req_ack <= 1'b0;
            i2c_error         <= 1'b0;
            bfm_cnt           <= 0;
            err_seen          <= 0;
            n_acks            <= 0;
            n_reqs            <= 0;
            req_d             <= 1'b0;
        end else begin
            req_d <= i2c_write_req;
            if (i2c_write_req && !req_d) begin
                if (n_reqs < 32) start_cyc[n_reqs] <= cyc;
                n_reqs <= n_reqs + 1;
            end
            if (i2c_write_req_ack) begin
                i2c_write_req_ack <= 1'b0;
                i2c_error         <= 1'b0;
                bfm_cnt           <= 0;
                if (i2c_write_req) begin
                    if (n_acks < 32) begin
                        log_entry[n_acks] <= {i2c_slave_dev_addr, i2c_write_addr, i2c_write_data};
                        log_cyc[n_acks]   <= cyc;
                    end
                    n_acks <= n_acks + 1;
                end
            end else if (i2c_write_req) begin
                if (bfm_cnt >= ack_delay) begin
                    i2c_write_req_ack <= 1'b1;
                    if ((lut_index == err_idx) && (err_seen < err_n)) begin
                        i2c_error <= 1'b1;
                        err_seen  <= err_seen + 1;
                    end else begin
                        i2c_error <= 1'b0;
                    end
                end else begin
                    bfm_cnt <= bfm_cnt + 1;
                end
            end else begin
                bfm_cnt <= 0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rel_cyc = cyc;
    endtask

    task automatic wait_end(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cfg_done || cfg_error) break;
        end
        check_eq({tag, "_end_reached"}, 32'(cfg_done | cfg_error), 32'd1);
    endtask

    task automatic wait_reqs(input string tag, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (n_reqs >= n) break;
        end
        check_eq({tag, "_req_seen"}, 32'(n_reqs >= n), 32'd1);
    endtask

    // Table A: four writes then terminator at index 4.
    task automatic table_a();
        for (int i = 0; i < 16; i++) lut_mem[i] = 32'hFF00_0000;
        lut_mem[0] = 32'h7831_0311;
        lut_mem[1] = 32'h7830_17FF;
        lut_mem[2] = 32'h7830_18FF;
        lut_mem[3] = 32'h7830_3418;
    endtask

    task automatic pulse_restart();
        cfg_restart = 1'b1;
        @(negedge clk);
        cfg_restart = 1'b0;
    endtask

    initial begin
        // ---------------- 1: reset state and plain 4-entry table
        table_a();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_busy",  32'(cfg_busy),      32'd1);
        check_eq("rst_done",  32'(cfg_done),      32'd0);
        check_eq("rst_error", 32'(cfg_error),     32'd0);
        check_eq("rst_req",   32'(i2c_write_req), 32'd0);
        check_eq("rst_index", 32'(lut_index),     32'd0);
        check_eq("rst_count", 32'(reg_count),     32'd0);
        check_eq("rst_fields", {i2c_slave_dev_addr, i2c_write_addr, i2c_write_data}, 32'd0);
        do_reset();
        wait_reqs("t1", 1, 400);
        // First req rises P_PWR+3 edges after release: power-up, FETCH, CHECK.
        check_eq("t1_pwr_wait", 32'(start_cyc[0] - rel_cyc >= P_PWR), 32'd1);
        check_eq("t1_req_fields", {i2c_slave_dev_addr, i2c_write_addr, i2c_write_data}, 32'h7831_0311);
        check_eq("t1_req_level", 32'(i2c_write_req), 32'd1);
        wait_end("t1", 400);
        check_eq("t1_done",   32'(cfg_done),  32'd1);
        check_eq("t1_busy",   32'(cfg_busy),  32'd0);
        check_eq("t1_error",  32'(cfg_error), 32'd0);
        check_eq("t1_count",  32'(reg_count), 32'd4);
        check_eq("t1_index",  32'(lut_index), 32'd4);
        check_eq("t1_acks",   32'(n_acks),    32'd4);
        check_eq("t1_req_off", 32'(i2c_write_req), 32'd0);
        check_eq("t1_w0", log_entry[0], 32'h7831_0311);
        check_eq("t1_w1", log_entry[1], 32'h7830_17FF);
        check_eq("t1_w2", log_entry[2], 32'h7830_18FF);
        check_eq("t1_w3", log_entry[3], 32'h7830_3418);

        // ---------------- 2: soft-reset settle wait
        for (int i = 0; i < 16; i++) lut_mem[i] = 32'hFF00_0000;
        lut_mem[0] = 32'h7831_0311;
        lut_mem[1] = 32'h7830_0882;
        lut_mem[2] = 32'h7831_0411;
        lut_mem[3] = 32'h7830_0842;
        lut_mem[4] = 32'h7831_0512;
        ack_delay = 4;
        do_reset();
        wait_end("t2", 600);
        check_eq("t2_done",  32'(cfg_done),  32'd1);
        check_eq("t2_count", 32'(reg_count), 32'd5);
        check_eq("t2_settle_gap", 32'(start_cyc[2] - log_cyc[1] >= P_SETTLE), 32'd1);
        // Without settle: ack edge -> FETCH, CHECK, REQ => req seen 3 edges later.
        check_eq("t2_no_settle_gap_bit7_clear", 32'(start_cyc[4] - log_cyc[3]), 32'd3);
        check_eq("t2_no_settle_gap_plain",      32'(start_cyc[1] - log_cyc[0]), 32'd3);
        ack_delay = 2;

        // ---------------- 3: I2C error on entry 2
        table_a();
        err_idx = 10'd2;
`ifdef CFG_RETRY_EN
        err_n = 3;
        do_reset();
        wait_end("t3a", 600);
        check_eq("t3a_done",  32'(cfg_done),  32'd1);
        check_eq("t3a_error", 32'(cfg_error), 32'd0);
        check_eq("t3a_count", 32'(reg_count), 32'd4);
        check_eq("t3a_acks",  32'(n_acks),    32'd7);
        err_n = 4;
        do_reset();
        wait_end("t3b", 600);
        check_eq("t3b_error", 32'(cfg_error), 32'd1);
        check_eq("t3b_done",  32'(cfg_done),  32'd0);
        check_eq("t3b_index", 32'(lut_index), 32'd2);
        check_eq("t3b_count", 32'(reg_count), 32'd2);
        check_eq("t3b_reqs",  32'(n_reqs),    32'd6);
`else
        err_n = 1;
        do_reset();
        wait_end("t3", 600);
        check_eq("t3_error", 32'(cfg_error), 32'd1);
        check_eq("t3_done",  32'(cfg_done),  32'd0);
        check_eq("t3_busy",  32'(cfg_busy),  32'd0);
        check_eq("t3_index", 32'(lut_index), 32'd2);
        check_eq("t3_count", 32'(reg_count), 32'd2);
        repeat (20) @(negedge clk);
        check_eq("t3_no_more_reqs", 32'(n_reqs), 32'd3);
        check_eq("t3_req_low", 32'(i2c_write_req), 32'd0);
`endif
        err_n = 0;

        // ---------------- 4: no terminator, MAX_ENTRIES=8
        for (int i = 0; i < 16; i++) lut_mem[i] = 32'h7831_0000 + 32'(i * 257);
        do_reset();
        wait_end("t4", 600);
        check_eq("t4_error", 32'(cfg_error), 32'd1);
        check_eq("t4_done",  32'(cfg_done),  32'd0);
        check_eq("t4_index", 32'(lut_index), 32'd8);
        check_eq("t4_count", 32'(reg_count), 32'd8);
        check_eq("t4_acks",  32'(n_acks),    32'd8);

        // ---------------- 5: async reset during REQ of entry 3
        table_a();
        do_reset();
        wait_reqs("t5", 4, 600);
        check_eq("t5_req_before", 32'(i2c_write_req), 32'd1);
        check_eq("t5_index_before", 32'(lut_index), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        check_eq("t5_req_dropped", 32'(i2c_write_req), 32'd0);
        check_eq("t5_index_cleared", 32'(lut_index), 32'd0);
        check_eq("t5_busy", 32'(cfg_busy), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        rel_cyc = cyc;
        wait_end("t5", 600);
        check_eq("t5_pwr_wait", 32'(start_cyc[0] - rel_cyc >= P_PWR), 32'd1);
        check_eq("t5_done",  32'(cfg_done),  32'd1);
        check_eq("t5_count", 32'(reg_count), 32'd4);
        check_eq("t5_acks",  32'(n_acks),    32'd4);
        check_eq("t5_w0", log_entry[0], 32'h7831_0311);

        // ---------------- 6: restart ignored while busy, honoured in DONE
        table_a();
        do_reset();
        wait_reqs("t6", 2, 600);
        pulse_restart();
        wait_end("t6a", 600);
        check_eq("t6_busy_restart_ignored_acks", 32'(n_acks), 32'd4);
        check_eq("t6a_count", 32'(reg_count), 32'd4);
        pulse_restart();
        rel_cyc = cyc;
        check_eq("t6_restart_busy",  32'(cfg_busy),  32'd1);
        check_eq("t6_restart_done",  32'(cfg_done),  32'd0);
        check_eq("t6_restart_count", 32'(reg_count), 32'd0);
        check_eq("t6_restart_index", 32'(lut_index), 32'd0);
        wait_end("t6b", 600);
        check_eq("t6b_done",  32'(cfg_done),  32'd1);
        check_eq("t6b_count", 32'(reg_count), 32'd4);
        check_eq("t6b_acks",  32'(n_acks),    32'd8);
        check_eq("t6b_w4", log_entry[4], 32'h7831_0311);
        check_eq("t6b_w7", log_entry[7], 32'h7830_3418);
        check_eq("t6b_no_pwr_wait", 32'(start_cyc[4] - rel_cyc < 10), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
